// File: rtl/bp_pkg.sv
// Shared definitions for the branch predict unit: compare-mode encodings,
// 2-bit saturating counter states and the counter step function.
package bp_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLEZ = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BLTZ = 3'd4,
        BR_BGEZ = 3'd5,
        BR_RSV6 = 3'd6,
        BR_RSV7 = 3'd7
    } brOp_e;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctrState_e;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == CTR_ST) ? ctr : ctr + 2'd1;
        else
            return (ctr == CTR_SNT) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer storage: two combinational read ports
// (fetch lookup, decode training) and one synchronous write port.
module bp_btb
    import bp_pkg::*;
#(
    parameter int width   = 32,
    parameter int entries = 16,
    localparam int idxW   = $clog2(entries),
    localparam int tagW   = width - idxW - 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [idxW-1:0]   fIdx,
    output logic              fValid,
    output logic [tagW-1:0]   fTag,
    output logic [width-1:0]  fTarget,
    output logic              fIsJump,
    output logic [1:0]        fCtr,
    input  logic [idxW-1:0]   dIdx,
    output logic              dValid,
    output logic [tagW-1:0]   dTag,
    output logic [width-1:0]  dTarget,
    output logic              dIsJump,
    output logic [1:0]        dCtr,
    input  logic              wrEn,
    input  logic [idxW-1:0]   wrIdx,
    input  logic              wrValid,
    input  logic [tagW-1:0]   wrTag,
    input  logic [width-1:0]  wrTarget,
    input  logic              wrIsJump,
    input  logic [1:0]        wrCtr
);

    logic              validMem  [entries];
    logic [tagW-1:0]   tagMem    [entries];
    logic [width-1:0]  targetMem [entries];
    logic              jumpMem   [entries];
    logic [1:0]        ctrMem    [entries];

    assign fValid  = validMem[fIdx];
    assign fTag    = tagMem[fIdx];
    assign fTarget = targetMem[fIdx];
    assign fIsJump = jumpMem[fIdx];
    assign fCtr    = ctrMem[fIdx];

    assign dValid  = validMem[dIdx];
    assign dTag    = tagMem[dIdx];
    assign dTarget = targetMem[dIdx];
    assign dIsJump = jumpMem[dIdx];
    assign dCtr    = ctrMem[dIdx];

    // Reads are combinational off the flops, so a same-cycle write is seen next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < entries; i++) begin
                validMem[i]  <= 1'b0;
                tagMem[i]    <= '0;
                targetMem[i] <= '0;
                jumpMem[i]   <= 1'b0;
                ctrMem[i]    <= CTR_WNT;
            end
        end else if (wrEn) begin
            validMem[wrIdx]  <= wrValid;
            tagMem[wrIdx]    <= wrTag;
            targetMem[wrIdx] <= wrTarget;
            jumpMem[wrIdx]   <= wrIsJump;
            ctrMem[wrIdx]    <= wrCtr;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage BTB prediction with decode-stage resolution, misprediction and training.
// Defining BP_STATS_EN adds the bpBranches / bpMispredicts counters.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int width   = 32,
    parameter int entries = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] pc_F,
    output logic             predTaken_F,
    output logic [width-1:0] predPC_F,
    input  logic [width-1:0] pc_D,
    input  logic [width-1:0] instr_D,
    input  logic             predTaken_D,
    input  logic [width-1:0] predPC_D,
    input  logic             branch_D,
    input  logic             jump_D,
    input  logic [2:0]       brOp_D,
    input  logic             stall_D,
    input  logic [1:0]       for_A_D,
    input  logic [1:0]       for_B_D,
    input  logic [width-1:0] rfOut_1D,
    input  logic [width-1:0] rfOut_2D,
    input  logic [width-1:0] out_M1,
    input  logic [width-1:0] out_M2,
    output logic             isBJ_D,
    output logic             realBJ_D,
    output logic             mispredict_D,
    output logic [width-1:0] redirectPC_D
`ifdef BP_STATS_EN
    ,
    output logic [width-1:0] bpBranches,
    output logic [width-1:0] bpMispredicts
`endif
);

    localparam int idxW = $clog2(entries);
    localparam int tagW = width - idxW - 2;

    logic [idxW-1:0]  idxF, idxD;
    logic [tagW-1:0]  tagF, tagD, entTagF, entTagD;
    logic             validF, validD, isJumpF, isJumpD, hitF, hitD;
    logic [width-1:0] targetF, targetEntD;
    logic [1:0]       ctrF, ctrD;

    logic [width-1:0] opA, opB, pcPlus4D, offsetSext, brTarget, jTarget, target;
    logic             cond;

    logic             wrEn, wrValid, wrIsJump;
    logic [tagW-1:0]  wrTag;
    logic [width-1:0] wrTarget;
    logic [1:0]       wrCtr;
    logic             unusedBits;

    assign idxF = pc_F[idxW+1:2];
    assign tagF = pc_F[width-1:idxW+2];
    assign idxD = pc_D[idxW+1:2];
    assign tagD = pc_D[width-1:idxW+2];

    bp_btb #(.width(width), .entries(entries)) uBtb (
        .clk      (clk),
        .rst_n    (rst_n),
        .fIdx     (idxF),
        .fValid   (validF),
        .fTag     (entTagF),
        .fTarget  (targetF),
        .fIsJump  (isJumpF),
        .fCtr     (ctrF),
        .dIdx     (idxD),
        .dValid   (validD),
        .dTag     (entTagD),
        .dTarget  (targetEntD),
        .dIsJump  (isJumpD),
        .dCtr     (ctrD),
        .wrEn     (wrEn),
        .wrIdx    (idxD),
        .wrValid  (wrValid),
        .wrTag    (wrTag),
        .wrTarget (wrTarget),
        .wrIsJump (wrIsJump),
        .wrCtr    (wrCtr)
    );

    assign hitF        = validF && (entTagF == tagF);
    assign hitD        = validD && (entTagD == tagD);
    assign predTaken_F = hitF && (isJumpF || ctrF[1]);
    assign predPC_F    = predTaken_F ? targetF : pc_F + width'(4);

    always_comb begin
        case (for_A_D)
            2'd0:    opA = rfOut_1D;
            2'd1:    opA = out_M1;
            2'd2:    opA = out_M2;
            default: opA = '0;
        endcase
        case (for_B_D)
            2'd0:    opB = rfOut_2D;
            2'd1:    opB = out_M1;
            2'd2:    opB = out_M2;
            default: opB = '0;
        endcase
    end

    // Signed tests only need the sign bit and a zero check of operand A.
    always_comb begin
        cond = 1'b0;
        case (brOp_D)
            BR_BEQ:  cond = (opA == opB);
            BR_BNE:  cond = (opA != opB);
            BR_BLEZ: cond = opA[width-1] || (opA == '0);
            BR_BGTZ: cond = !opA[width-1] && (opA != '0);
            BR_BLTZ: cond = opA[width-1];
            BR_BGEZ: cond = !opA[width-1];
            default: cond = 1'b0;
        endcase
    end

    assign pcPlus4D   = pc_D + width'(4);
    assign offsetSext = {{(width-16){instr_D[15]}}, instr_D[15:0]};
    assign brTarget   = pcPlus4D + (offsetSext << 2);
    assign jTarget    = {pcPlus4D[width-1:28], instr_D[25:0], 2'b00};
    assign target     = jump_D ? jTarget : brTarget;

    assign isBJ_D       = branch_D || jump_D;
    assign realBJ_D     = jump_D || (branch_D && cond);
    assign redirectPC_D = realBJ_D ? target : pcPlus4D;
    assign mispredict_D = !stall_D && ((realBJ_D != predTaken_D) ||
                                       (realBJ_D && predTaken_D && (target != predPC_D)));

    // A non-control instruction that was predicted taken clears the stale entry it hit.
    always_comb begin
        wrEn     = 1'b0;
        wrValid  = 1'b0;
        wrTag    = tagD;
        wrTarget = target;
        wrIsJump = jump_D;
        wrCtr    = CTR_WT;
        if (!stall_D) begin
            if (isBJ_D) begin
                if (hitD) begin
                    wrEn    = 1'b1;
                    wrValid = 1'b1;
                    wrCtr   = jump_D ? CTR_ST : ctr_next(ctrD, realBJ_D);
                end else if (realBJ_D) begin
                    wrEn    = 1'b1;
                    wrValid = 1'b1;
                    wrCtr   = jump_D ? CTR_ST : CTR_WT;
                end
            end else if (predTaken_D && hitD) begin
                wrEn     = 1'b1;
                wrValid  = 1'b0;
                wrTarget = targetEntD;
                wrIsJump = isJumpD;
                wrCtr    = ctrD;
            end
        end
    end

    assign unusedBits = ^{instr_D[31:26], ctrF[0]};

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpBranches    <= '0;
            bpMispredicts <= '0;
        end else if (!stall_D) begin
            if (isBJ_D)
                bpBranches <= bpBranches + width'(1);
            if (mispredict_D)
                bpMispredicts <= bpMispredicts + width'(1);
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit; the stats scenario
// runs only when BP_STATS_EN is defined.
module tb_branch_predict_unit;
    import bp_pkg::*;

    localparam int width   = 32;
    localparam int entries = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [width-1:0] pc_F, predPC_F, pc_D, instr_D, predPC_D;
    logic [width-1:0] rfOut_1D, rfOut_2D, out_M1, out_M2, redirectPC_D;
    logic             predTaken_F, predTaken_D, branch_D, jump_D, stall_D;
    logic             isBJ_D, realBJ_D, mispredict_D;
    logic [2:0]       brOp_D;
    logic [1:0]       for_A_D, for_B_D;
`ifdef BP_STATS_EN
    logic [width-1:0] bpBranches, bpMispredicts;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.width(width), .entries(entries)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_F         (pc_F),
        .predTaken_F  (predTaken_F),
        .predPC_F     (predPC_F),
        .pc_D         (pc_D),
        .instr_D      (instr_D),
        .predTaken_D  (predTaken_D),
        .predPC_D     (predPC_D),
        .branch_D     (branch_D),
        .jump_D       (jump_D),
        .brOp_D       (brOp_D),
        .stall_D      (stall_D),
        .for_A_D      (for_A_D),
        .for_B_D      (for_B_D),
        .rfOut_1D     (rfOut_1D),
        .rfOut_2D     (rfOut_2D),
        .out_M1       (out_M1),
        .out_M2       (out_M2),
        .isBJ_D       (isBJ_D),
        .realBJ_D     (realBJ_D),
        .mispredict_D (mispredict_D),
        .redirectPC_D (redirectPC_D)
`ifdef BP_STATS_EN
        ,
        .bpBranches    (bpBranches),
        .bpMispredicts (bpMispredicts)
`endif
    );

    task automatic idleDecode();
        pc_D = '0; instr_D = '0; predTaken_D = 1'b0; predPC_D = '0;
        branch_D = 1'b0; jump_D = 1'b0; brOp_D = BR_BEQ; stall_D = 1'b0;
        for_A_D = 2'd0; for_B_D = 2'd0;
        rfOut_1D = '0; rfOut_2D = '0; out_M1 = '0; out_M2 = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idleDecode();
        pc_F = 32'h100;
        #3;
        checks++; if (predTaken_F !== 1'b0) $display("[TB] FAIL rst_predTaken: got %b expected 0", predTaken_F); else passes++;
        checks++; if (predPC_F !== 32'h104) $display("[TB] FAIL rst_predPC: got %h expected 00000104", predPC_F); else passes++;
        checks++; if (mispredict_D !== 1'b0) $display("[TB] FAIL rst_mispredict: got %b expected 0", mispredict_D); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        checks++; if (predTaken_F !== 1'b0) $display("[TB] FAIL post_rst_predTaken: got %b expected 0", predTaken_F); else passes++;
        checks++; if (predPC_F !== 32'h104) $display("[TB] FAIL post_rst_predPC: got %h expected 00000104", predPC_F); else passes++;
    endtask

    task automatic test_cold_branch();
        pc_D = 32'h100; instr_D = 32'h0000_0004; branch_D = 1'b1; brOp_D = BR_BEQ;
        rfOut_1D = 32'd5; rfOut_2D = 32'd5; predTaken_D = 1'b0;
        #1;
        checks++; if (isBJ_D !== 1'b1) $display("[TB] FAIL cold_isBJ: got %b expected 1", isBJ_D); else passes++;
        checks++; if (realBJ_D !== 1'b1) $display("[TB] FAIL cold_realBJ: got %b expected 1", realBJ_D); else passes++;
        checks++; if (mispredict_D !== 1'b1) $display("[TB] FAIL cold_mispredict: got %b expected 1", mispredict_D); else passes++;
        checks++; if (redirectPC_D !== 32'h114) $display("[TB] FAIL cold_redirect: got %h expected 00000114", redirectPC_D); else passes++;
        checks++; if (predTaken_F !== 1'b0) $display("[TB] FAIL cold_same_cycle_read: got %b expected 0", predTaken_F); else passes++;
        nextCycle();
        idleDecode();
        #1;
        checks++; if (predTaken_F !== 1'b1) $display("[TB] FAIL cold_predTaken: got %b expected 1", predTaken_F); else passes++;
        checks++; if (predPC_F !== 32'h114) $display("[TB] FAIL cold_predPC: got %h expected 00000114", predPC_F); else passes++;
    endtask

    task automatic test_training();
        // Counter walk from WT: NT,NT -> SNT; T,T,T -> ST; NT -> WT; T with wrong predPC.
        bit               taken     [7] = '{0, 0, 1, 1, 1, 0, 1};
        bit               predD     [7] = '{1, 0, 0, 0, 1, 1, 1};
        logic [width-1:0] predPCD   [7] = '{32'h114, 32'h0, 32'h0, 32'h0, 32'h114, 32'h114, 32'h200};
        bit               expMisp   [7] = '{1, 0, 1, 1, 0, 1, 1};
        bit               expPredF  [7] = '{0, 0, 0, 1, 1, 1, 1};
        logic [width-1:0] expRedir  [7] = '{32'h104, 32'h104, 32'h114, 32'h114, 32'h114, 32'h104, 32'h114};
        for (int i = 0; i < 7; i++) begin
            pc_D = 32'h100; instr_D = 32'h0000_0004; branch_D = 1'b1; brOp_D = BR_BEQ;
            rfOut_1D = 32'd5; rfOut_2D = taken[i] ? 32'd5 : 32'd6;
            predTaken_D = predD[i]; predPC_D = predPCD[i];
            #1;
            checks++; if (mispredict_D !== expMisp[i]) $display("[TB] FAIL train%0d_mispredict: got %b expected %b", i, mispredict_D, expMisp[i]); else passes++;
            checks++; if (redirectPC_D !== expRedir[i]) $display("[TB] FAIL train%0d_redirect: got %h expected %h", i, redirectPC_D, expRedir[i]); else passes++;
            nextCycle();
            checks++; if (predTaken_F !== expPredF[i]) $display("[TB] FAIL train%0d_predTaken_F: got %b expected %b", i, predTaken_F, expPredF[i]); else passes++;
        end
        idleDecode();
    endtask

    task automatic test_signed_compare();
        logic [2:0]       op    [8] = '{BR_BLTZ, BR_BGTZ, BR_BLEZ, BR_BGEZ, BR_BGTZ, BR_BNE, BR_RSV6, BR_BEQ};
        logic [1:0]       fa    [8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
        logic [1:0]       fb    [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
        logic [width-1:0] rf1   [8] = '{32'hFFFF_FFFF, 32'h0, 32'h7, 32'h8000_0000, 32'h7FFF_FFFF, 32'h4, 32'h3, 32'h9};
        logic [width-1:0] rf2   [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h9, 32'h3, 32'h0};
        logic [width-1:0] m2    [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0};
        bit               expBJ [8] = '{1, 0, 1, 0, 1, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            // Offset -1 word: taken target is pc_D itself.
            pc_D = 32'h1010; instr_D = 32'h0000_FFFF; branch_D = 1'b1; brOp_D = op[i];
            for_A_D = fa[i]; for_B_D = fb[i]; rfOut_1D = rf1[i]; rfOut_2D = rf2[i];
            out_M1 = 32'h0; out_M2 = m2[i]; predTaken_D = 1'b0;
            #1;
            checks++; if (realBJ_D !== expBJ[i]) $display("[TB] FAIL cmp%0d_realBJ: got %b expected %b", i, realBJ_D, expBJ[i]); else passes++;
            checks++; if (redirectPC_D !== (expBJ[i] ? 32'h1010 : 32'h1014)) $display("[TB] FAIL cmp%0d_redirect: got %h expected %h", i, redirectPC_D, (expBJ[i] ? 32'h1010 : 32'h1014)); else passes++;
            nextCycle();
        end
        idleDecode();
    endtask

    task automatic test_jump_stall_alias();
        pc_F = 32'h0040_0008;
        pc_D = 32'h0040_0008; instr_D = 32'h0800_0010; jump_D = 1'b1; stall_D = 1'b1; predTaken_D = 1'b0;
        #1;
        checks++; if (mispredict_D !== 1'b0) $display("[TB] FAIL jstall_mispredict: got %b expected 0", mispredict_D); else passes++;
        checks++; if (realBJ_D !== 1'b1) $display("[TB] FAIL jstall_realBJ: got %b expected 1", realBJ_D); else passes++;
        checks++; if (redirectPC_D !== 32'h0000_0040) $display("[TB] FAIL jstall_redirect: got %h expected 00000040", redirectPC_D); else passes++;
        nextCycle();
        checks++; if (predTaken_F !== 1'b0) $display("[TB] FAIL jstall_no_write: got %b expected 0", predTaken_F); else passes++;
        stall_D = 1'b0;
        #1;
        checks++; if (mispredict_D !== 1'b1) $display("[TB] FAIL jump_mispredict: got %b expected 1", mispredict_D); else passes++;
        nextCycle();
        checks++; if (predTaken_F !== 1'b1) $display("[TB] FAIL jump_predTaken_F: got %b expected 1", predTaken_F); else passes++;
        checks++; if (predPC_F !== 32'h0000_0040) $display("[TB] FAIL jump_predPC_F: got %h expected 00000040", predPC_F); else passes++;
        predTaken_D = 1'b1; predPC_D = 32'h0000_0040;
        #1;
        checks++; if (mispredict_D !== 1'b0) $display("[TB] FAIL jump_correct_pred: got %b expected 0", mispredict_D); else passes++;
        nextCycle();
        // Non-branch predicted taken but at a different tag: mispredict, entry survives.
        idleDecode();
        pc_D = 32'h0040_0048; predTaken_D = 1'b1; predPC_D = 32'h0000_0040;
        #1;
        checks++; if (mispredict_D !== 1'b1) $display("[TB] FAIL alias_miss_mispredict: got %b expected 1", mispredict_D); else passes++;
        checks++; if (redirectPC_D !== 32'h0040_004C) $display("[TB] FAIL alias_miss_redirect: got %h expected 0040004c", redirectPC_D); else passes++;
        nextCycle();
        checks++; if (predTaken_F !== 1'b1) $display("[TB] FAIL alias_miss_kept: got %b expected 1", predTaken_F); else passes++;
        pc_D = 32'h0040_0008;
        #1;
        checks++; if (isBJ_D !== 1'b0) $display("[TB] FAIL alias_isBJ: got %b expected 0", isBJ_D); else passes++;
        checks++; if (redirectPC_D !== 32'h0040_000C) $display("[TB] FAIL alias_redirect: got %h expected 0040000c", redirectPC_D); else passes++;
        nextCycle();
        checks++; if (predTaken_F !== 1'b0) $display("[TB] FAIL alias_invalidated: got %b expected 0", predTaken_F); else passes++;
        checks++; if (predPC_F !== 32'h0040_000C) $display("[TB] FAIL alias_predPC_F: got %h expected 0040000c", predPC_F); else passes++;
        idleDecode();
    endtask

    task automatic test_reset_mid_update();
        pc_F = 32'h100;
        #1;
        checks++; if (predTaken_F !== 1'b1) $display("[TB] FAIL midrst_pre_predTaken: got %b expected 1", predTaken_F); else passes++;
        pc_D = 32'h100; instr_D = 32'h0000_0004; branch_D = 1'b1; brOp_D = BR_BEQ;
        rfOut_1D = 32'd1; rfOut_2D = 32'd1; predTaken_D = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (predTaken_F !== 1'b0) $display("[TB] FAIL midrst_predTaken: got %b expected 0", predTaken_F); else passes++;
        checks++; if (predPC_F !== 32'h104) $display("[TB] FAIL midrst_predPC: got %h expected 00000104", predPC_F); else passes++;
        checks++; if (mispredict_D !== 1'b1) $display("[TB] FAIL midrst_comb_mispredict: got %b expected 1", mispredict_D); else passes++;
        nextCycle();
        idleDecode();
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        checks++; if (predTaken_F !== 1'b0) $display("[TB] FAIL midrst_update_lost: got %b expected 0", predTaken_F); else passes++;
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        nextCycle();
        checks++; if (bpBranches !== 32'd0) $display("[TB] FAIL stats_rst_branches: got %0d expected 0", bpBranches); else passes++;
        for (int i = 0; i < 10; i++) begin
            pc_D = 32'h3000 + 32'(4 * i); instr_D = 32'h0000_0010; branch_D = 1'b1; brOp_D = BR_BEQ;
            rfOut_1D = 32'd5; rfOut_2D = (i == 2 || i == 5 || i == 8) ? 32'd5 : 32'd6;
            predTaken_D = 1'b0;
            nextCycle();
        end
        // A stalled taken branch and an idle slot must not be counted.
        pc_D = 32'h3100; rfOut_2D = 32'd5; stall_D = 1'b1;
        nextCycle();
        idleDecode();
        nextCycle();
        checks++; if (bpBranches !== 32'd10) $display("[TB] FAIL stats_branches: got %0d expected 10", bpBranches); else passes++;
        checks++; if (bpMispredicts !== 32'd3) $display("[TB] FAIL stats_mispredicts: got %0d expected 3", bpMispredicts); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (bpBranches !== 32'd0) $display("[TB] FAIL stats_async_branches: got %0d expected 0", bpBranches); else passes++;
        checks++; if (bpMispredicts !== 32'd0) $display("[TB] FAIL stats_async_mispredicts: got %0d expected 0", bpMispredicts); else passes++;
        #2;
        rst_n = 1'b1;
        nextCycle();
    endtask
`endif

    initial begin
        $display("[TB] branch_predict_unit directed tests");
        test_reset();
        test_cold_branch();
        test_training();
        test_signed_compare();
        test_jump_stall_alias();
        test_reset_mid_update();
`ifdef BP_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
